line_buffer3: RTL

- Upstream feeder for the 3-line box/Sobel filter.
- Accepts one raster-order pixel stream, 64-bit words of 8 × 8-bit pixels, from a PCIe stream channel.
- Stores the two previous image lines in block RAM.
- Emits three column-aligned words (row r-2, row r-1, row r) on three valid/ack lanes that feed the filter's line1/line2/line3 inputs.

---
 rtl/lb_pkg.sv | 26 ++
 rtl/line_buffer3_if.sv | 35 +++
 rtl/line_ram.sv | 28 ++
 rtl/line_buffer3.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - shared defaults, lane indices and row classification for line_buffer3
package lb_pkg;

   localparam int LB_DATA_W      = 64;
   localparam int LB_LINE_WORDS  = 160;
   localparam int LB_FRAME_LINES = 720;
   localparam int LB_ADDR_W      = 8;

   localparam int NUM_LANES = 3;
   localparam int LANE1     = 0;
   localparam int LANE2     = 1;
   localparam int LANE3     = 2;

   typedef enum logic [1:0] {
      ROW_FIRST  = 2'd0,
      ROW_SECOND = 2'd1,
      ROW_BODY   = 2'd2
   } row_kind_e;

   function automatic row_kind_e classify_row(input int unsigned row);
      if (row == 0) return ROW_FIRST;
      if (row == 1) return ROW_SECOND;
      return ROW_BODY;
   endfunction

endpackage

// File: rtl/line_buffer3_if.sv
// rtl/line_buffer3_if.sv - input stream and three output lanes of line_buffer3
interface line_buffer3_if #(
   parameter int DATA_W = lb_pkg::LB_DATA_W
);
   logic              i_data_valid;
   logic [DATA_W-1:0] i_data;
   logic              o_data_ack;
   logic              o_line1_data_valid;
   logic [DATA_W-1:0] o_line1_data;
   logic              i_line1_data_ack;
   logic              o_line2_data_valid;
   logic [DATA_W-1:0] o_line2_data;
   logic              i_line2_data_ack;
   logic              o_line3_data_valid;
   logic [DATA_W-1:0] o_line3_data;
   logic              i_line3_data_ack;

   modport slave (
      input  i_data_valid, i_data,
      input  i_line1_data_ack, i_line2_data_ack, i_line3_data_ack,
      output o_data_ack,
      output o_line1_data_valid, o_line1_data,
      output o_line2_data_valid, o_line2_data,
      output o_line3_data_valid, o_line3_data
   );

   modport master (
      output i_data_valid, i_data,
      output i_line1_data_ack, i_line2_data_ack, i_line3_data_ack,
      input  o_data_ack,
      input  o_line1_data_valid, o_line1_data,
      input  o_line2_data_valid, o_line2_data,
      input  o_line3_data_valid, o_line3_data
   );
endinterface

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port read-first line memory, one-cycle registered read
module line_ram
   import lb_pkg::*;
#(
   parameter int DATA_W = LB_DATA_W,
   parameter int ADDR_W = LB_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;

   // read data holds when i_rd_en is low, so a stalled stage keeps its operands
   always_ff @(posedge i_clk) begin
      if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
      if (i_rd_en) rd_data_q <= mem_q[i_rd_addr];
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/line_buffer3.sv
// rtl/line_buffer3.sv - two-line buffer emitting column-aligned rows r-2/r-1/r on three lanes
// LB_BORDER_REPLICATE_EN: also emit the first two rows of a frame with top-border replication
module line_buffer3
   import lb_pkg::*;
#(
   parameter int DATA_W      = LB_DATA_W,
   parameter int LINE_WORDS  = LB_LINE_WORDS,
   parameter int FRAME_LINES = LB_FRAME_LINES,
   parameter int ADDR_W      = LB_ADDR_W
) (
   input logic           i_clk,
   input logic           i_rst,
   line_buffer3_if.slave lb
);

   localparam int ROW_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WORDS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(FRAME_LINES - 1);

   logic [ADDR_W-1:0] col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [ADDR_W-1:0] s1_col_q, s1_col_d;
   row_kind_e         s1_kind_q, s1_kind_d;

   logic [NUM_LANES-1:0]             lane_valid_q, lane_valid_d;
   logic [NUM_LANES-1:0][DATA_W-1:0] lane_data_q, lane_data_d;
   logic [NUM_LANES-1:0]             lane_ack;

   logic [DATA_W-1:0] ram_a_rd, ram_b_rd;
   logic              out_free, s1_primed, s1_advance, data_ack, accept;

   assign lane_ack = {lb.i_line3_data_ack, lb.i_line2_data_ack, lb.i_line1_data_ack};

`ifdef LB_BORDER_REPLICATE_EN
   assign s1_primed = 1'b1;
`else
   assign s1_primed = (s1_kind_q == ROW_BODY);
`endif

   assign out_free   = &(~lane_valid_q | lane_ack);
   assign s1_advance = s1_valid_q && (out_free || !s1_primed);
   assign data_ack   = !s1_valid_q || s1_advance;
   assign accept     = lb.i_data_valid && data_ack;

   // RAM_A holds row r-1, RAM_B row r-2; stage 1 shifts A into B as it writes the new row
   line_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_a (
      .i_clk     (i_clk),
      .i_rd_en   (accept),
      .i_rd_addr (col_q),
      .o_rd_data (ram_a_rd),
      .i_wr_en   (s1_advance),
      .i_wr_addr (s1_col_q),
      .i_wr_data (s1_data_q)
   );

   line_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_b (
      .i_clk     (i_clk),
      .i_rd_en   (accept),
      .i_rd_addr (col_q),
      .o_rd_data (ram_b_rd),
      .i_wr_en   (s1_advance),
      .i_wr_addr (s1_col_q),
      .i_wr_data (ram_a_rd)
   );

   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_col_d   = s1_col_q;
      s1_kind_d  = s1_kind_q;
      if (s1_advance) s1_valid_d = 1'b0;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_data_d  = lb.i_data;
         s1_col_d   = col_q;
         s1_kind_d  = classify_row(32'(row_q));
         if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + ADDR_W'(1);
         end
      end
   end

   // a lane retiring on the same edge a new triple loads is simply overwritten
   always_comb begin
      lane_valid_d = lane_valid_q & ~lane_ack;
      lane_data_d  = lane_data_q;
      if (s1_advance && s1_primed) begin
         lane_valid_d       = '1;
         lane_data_d[LANE1] = ram_b_rd;
         lane_data_d[LANE2] = ram_a_rd;
         lane_data_d[LANE3] = s1_data_q;
`ifdef LB_BORDER_REPLICATE_EN
         if (s1_kind_q == ROW_FIRST) begin
            lane_data_d[LANE1] = s1_data_q;
            lane_data_d[LANE2] = s1_data_q;
         end else if (s1_kind_q == ROW_SECOND) begin
            lane_data_d[LANE1] = ram_a_rd;
         end
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         col_q        <= '0;
         row_q        <= '0;
         s1_valid_q   <= 1'b0;
         lane_valid_q <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         s1_valid_q   <= s1_valid_d;
         lane_valid_q <= lane_valid_d;
      end
   end

   always_ff @(posedge i_clk) begin
      s1_data_q   <= s1_data_d;
      s1_col_q    <= s1_col_d;
      s1_kind_q   <= s1_kind_d;
      lane_data_q <= lane_data_d;
   end

   assign lb.o_data_ack         = data_ack;
   assign lb.o_line1_data_valid = lane_valid_q[LANE1];
   assign lb.o_line1_data       = lane_data_q[LANE1];
   assign lb.o_line2_data_valid = lane_valid_q[LANE2];
   assign lb.o_line2_data       = lane_data_q[LANE2];
   assign lb.o_line3_data_valid = lane_valid_q[LANE3];
   assign lb.o_line3_data       = lane_data_q[LANE3];

endmodule
